// File: rtl/host_cmd_serializer_if.sv
// host_cmd_serializer_if: command request bundle between a command source
// (master) and the UART command serializer (slave).
interface host_cmd_serializer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic                  CMD_VLD;
  logic                  CMD_RDY;
  logic [1:0]            CMD_TYPE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [7:0]            CMD_DATA0;
  logic [7:0]            CMD_DATA1;
  logic [FUN_WIDTH-1:0]  CMD_FUN;
  logic                  PAR_EN;
  logic                  PAR_TYP;

  modport master (
    output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA0, CMD_DATA1, CMD_FUN,
           PAR_EN, PAR_TYP,
    input  CMD_RDY
  );

  modport slave (
    input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA0, CMD_DATA1, CMD_FUN,
           PAR_EN, PAR_TYP,
    output CMD_RDY
  );
endinterface

// File: rtl/host_cmd_serializer.sv
// host_cmd_serializer: accepts one command request, builds the matching
// command frame (0xAA write, 0xBB read, 0xCC ALU+operands, 0xDD ALU) and
// shifts it out as 8-bit UART characters (start, 8 data LSB first, optional
// parity, stop) on an idle-high line.
// Optional feature: define HOST_CMD_GAP_EN to insert GAP_BITS idle-high bit
// periods between consecutive bytes of one frame.
module host_cmd_serializer #(
  parameter int BIT_CLKS   = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int GAP_BITS   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  host_cmd_serializer_if.slave cmd,
  output logic                 TX_S_DATA,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int               CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

  // Reject parameter values the counters cannot represent.
  if (BIT_CLKS < 1 || BIT_CLKS > 256) begin : g_bad_bit_clks
    $error("host_cmd_serializer: BIT_CLKS must be in 1..256");
  end
  if (GAP_BITS < 1) begin : g_bad_gap_bits
    $error("host_cmd_serializer: GAP_BITS must be at least 1");
  end

`ifdef HOST_CMD_GAP_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  localparam int               GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data0_q, data0_d;
  logic [7:0]            data1_q, data1_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic                  bit_end;
  logic                  last_byte;
  logic [1:0]            last_idx;
  logic [7:0]            cur_byte;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_idx  = (type_q == 2'd0) ? 2'd2 : (type_q == 2'd2) ? 2'd3 : 2'd1;
  assign last_byte = (byte_idx_q == last_idx);

  assign TX_S_DATA   = tx_q;
  assign DONE        = done_q;
  assign BUSY        = (state_q != IDLE);
  assign cmd.CMD_RDY = (state_q == IDLE);

  // State register: FSM, counters, latched command and the registered line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      type_q     <= '0;
      addr_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      fun_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef HOST_CMD_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      fun_q      <= fun_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef HOST_CMD_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  // Next-state logic: bit-period timing, bit/byte sequencing, command latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    fun_d      = fun_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
`ifdef HOST_CMD_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd.CMD_VLD) begin
          state_d    = START;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          type_d     = cmd.CMD_TYPE;
          addr_d     = cmd.CMD_ADDR;
          data0_d    = cmd.CMD_DATA0;
          data1_d    = cmd.CMD_DATA1;
          fun_d      = cmd.CMD_FUN;
          par_en_d   = cmd.PAR_EN;
          par_typ_d  = cmd.PAR_TYP;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
`ifdef HOST_CMD_GAP_EN
            state_d    = GAP;
            gap_cnt_d  = '0;
`else
            state_d    = START;
`endif
          end
        end
      end
`ifdef HOST_CMD_GAP_EN
      GAP: begin
        if (bit_end) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = START;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: line level for the upcoming cycle and the frame-done pulse.
  always_comb begin
    cur_byte = 8'hFF;
    case (type_q)
      2'd0: begin
        case (byte_idx_d)
          2'd0:    cur_byte = 8'hAA;
          2'd1:    cur_byte = 8'(addr_q);
          default: cur_byte = data0_q;
        endcase
      end
      2'd1: begin
        cur_byte = (byte_idx_d == 2'd0) ? 8'hBB : 8'(addr_q);
      end
      2'd2: begin
        case (byte_idx_d)
          2'd0:    cur_byte = 8'hCC;
          2'd1:    cur_byte = data0_q;
          2'd2:    cur_byte = data1_q;
          default: cur_byte = 8'(fun_q);
        endcase
      end
      default: begin
        cur_byte = (byte_idx_d == 2'd0) ? 8'hDD : 8'(fun_q);
      end
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      PARITY:  tx_d = (^cur_byte) ^ par_typ_q;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && bit_end && last_byte;
  end

endmodule

// File: tb/tb_host_cmd_serializer.sv
// tb_host_cmd_serializer: directed commands with hand-computed expected bytes,
// parity bits and DONE cycles; a line decoder and a DONE watcher check the
// DUT against queues filled when each command is issued.
`timescale 1ns/1ps
module tb_host_cmd_serializer;
  localparam int BIT_CLKS   = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int FUN_WIDTH  = 4;
  localparam int GAP_BITS   = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       par_en;
    logic       par;
  } exp_byte_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TX_S_DATA;
  logic BUSY;
  logic DONE;

  int unsigned cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          mon_en = 1'b1;
  exp_byte_t   byte_q[$];
  int unsigned done_q[$];

  host_cmd_serializer_if #(.ADDR_WIDTH(ADDR_WIDTH), .FUN_WIDTH(FUN_WIDTH)) cmd_if ();

  host_cmd_serializer #(
    .BIT_CLKS  (BIT_CLKS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .FUN_WIDTH (FUN_WIDTH),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cmd      (cmd_if),
    .TX_S_DATA(TX_S_DATA),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  // Free-running clock and a count of rising edges seen so far.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic pe, input logic p);
    exp_byte_t e;
    e.data   = d;
    e.par_en = pe;
    e.par    = p;
    byte_q.push_back(e);
  endtask

  // Called at a falling edge; drives a request, waits for its acceptance edge,
  // then scrambles the inputs so any late sampling corrupts the frame.
  task automatic apply_stimulus(input logic [1:0] t, input logic [3:0] a,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [3:0] f, input logic pe, input logic pt,
                                input int unsigned flen);
    int n = 0;
    cmd_if.CMD_VLD   = 1'b1;
    cmd_if.CMD_TYPE  = t;
    cmd_if.CMD_ADDR  = a;
    cmd_if.CMD_DATA0 = d0;
    cmd_if.CMD_DATA1 = d1;
    cmd_if.CMD_FUN   = f;
    cmd_if.PAR_EN    = pe;
    cmd_if.PAR_TYP   = pt;
    while (cmd_if.CMD_RDY !== 1'b1 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (cmd_if.CMD_RDY !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_wait: CMD_RDY still low after %0d cycles", n);
    end
    if (flen != 0) done_q.push_back(cyc + 1 + flen);
    @(negedge CLK);
    cmd_if.CMD_VLD   = 1'b0;
    cmd_if.CMD_TYPE  = ~t;
    cmd_if.CMD_ADDR  = ~a;
    cmd_if.CMD_DATA0 = ~d0;
    cmd_if.CMD_DATA1 = ~d1;
    cmd_if.CMD_FUN   = ~f;
    cmd_if.PAR_EN    = ~pe;
    cmd_if.PAR_TYP   = ~pt;
    check_output("busy_after_accept", BUSY, 1);
    check_output("rdy_after_accept", cmd_if.CMD_RDY, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (DONE !== 1'b1 && n < 2000);
    if (DONE !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: DONE not seen within %0d cycles, got 0 expected 1", name, n);
    end
  endtask

  // Line decoder: on each start bit, pops the expected byte and samples every
  // bit in the middle of its period.
  initial begin : line_monitor
    exp_byte_t  e;
    logic [7:0] got;
    forever begin
      @(negedge CLK);
      if (mon_en && RST === 1'b0 && TX_S_DATA === 1'b0) begin
        if (byte_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_start: start bit at cycle %0d, no byte expected", cyc);
          while (TX_S_DATA !== 1'b1) @(negedge CLK);
        end else begin
          e = byte_q.pop_front();
          repeat (BIT_CLKS / 2 - 1) @(negedge CLK);
          check_output("start_bit", TX_S_DATA, 0);
          for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge CLK);
            got[i] = TX_S_DATA;
          end
          check_output("data_byte", got, e.data);
          if (e.par_en) begin
            repeat (BIT_CLKS) @(negedge CLK);
            check_output("parity_bit", TX_S_DATA, e.par);
          end
          repeat (BIT_CLKS) @(negedge CLK);
          check_output("stop_bit", TX_S_DATA, 1);
        end
      end
    end
  end

  // DONE watcher: every pulse must match the next expected completion cycle.
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (done_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: DONE at cycle %0d, none expected", cyc);
      end else begin
        check_output("done_cycle", cyc, done_q.pop_front());
        check_output("rdy_at_done", cmd_if.CMD_RDY, 1);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd_if.CMD_VLD   = 1'b0;
    cmd_if.CMD_TYPE  = '0;
    cmd_if.CMD_ADDR  = '0;
    cmd_if.CMD_DATA0 = '0;
    cmd_if.CMD_DATA1 = '0;
    cmd_if.CMD_FUN   = '0;
    cmd_if.PAR_EN    = 1'b0;
    cmd_if.PAR_TYP   = 1'b0;

    // Reset held for two cycles, then released.
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_output("reset_tx", TX_S_DATA, 1);
    check_output("reset_rdy", cmd_if.CMD_RDY, 1);
    check_output("reset_busy", BUSY, 0);
    check_output("reset_done", DONE, 0);

    // Write, even parity: 3 bytes x 11 bits x 8 clocks.
    $display("[TB] write, even parity");
    push_byte(8'hAA, 1'b1, 1'b0);
    push_byte(8'h05, 1'b1, 1'b0);
    push_byte(8'h3C, 1'b1, 1'b0);
    apply_stimulus(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b1, 1'b0, 264);
    wait_done("write_done");

    // ALU with operands, no parity; a request raised mid-frame must be ignored.
    $display("[TB] ALU with operands, parity off");
    push_byte(8'hCC, 1'b0, 1'b0);
    push_byte(8'h0A, 1'b0, 1'b0);
    push_byte(8'h03, 1'b0, 1'b0);
    push_byte(8'h01, 1'b0, 1'b0);
    apply_stimulus(2'd2, 4'h0, 8'h0A, 8'h03, 4'h1, 1'b0, 1'b0, 320);
    repeat (50) @(negedge CLK);
    cmd_if.CMD_VLD  = 1'b1;
    cmd_if.CMD_TYPE = 2'd1;
    repeat (5) @(negedge CLK);
    check_output("rdy_while_busy", cmd_if.CMD_RDY, 0);
    cmd_if.CMD_VLD  = 1'b0;
    wait_done("alu_done");

    // Odd-parity read, then a back-to-back ALU command issued in the DONE cycle.
    $display("[TB] odd parity read with back-to-back command");
    push_byte(8'hBB, 1'b1, 1'b1);
    push_byte(8'h02, 1'b1, 1'b0);
    apply_stimulus(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 176);
    wait_done("read_done");
    push_byte(8'hDD, 1'b1, 1'b1);
    push_byte(8'h04, 1'b1, 1'b0);
    apply_stimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h4, 1'b1, 1'b1, 176);
    check_output("b2b_start_low", TX_S_DATA, 0);
    wait_done("b2b_done");

    // Reset pulsed during a data bit of byte 2 aborts the frame silently.
    $display("[TB] mid-frame reset");
    mon_en = 1'b0;
    apply_stimulus(2'd0, 4'h9, 8'h55, 8'h00, 4'h0, 1'b0, 1'b0, 0);
    repeat (100) @(negedge CLK);
    check_output("busy_before_abort", BUSY, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_output("abort_tx", TX_S_DATA, 1);
    check_output("abort_busy", BUSY, 0);
    check_output("abort_done", DONE, 0);
    check_output("abort_rdy", cmd_if.CMD_RDY, 1);
    repeat (30) @(negedge CLK);
    check_output("abort_tx_idle", TX_S_DATA, 1);
    mon_en = 1'b1;
    push_byte(8'hBB, 1'b0, 1'b0);
    push_byte(8'h0F, 1'b0, 1'b0);
    apply_stimulus(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 160);
    wait_done("after_abort_done");

    // ALU without operands, parity off; gap build adds 2 x 8 idle cycles.
    $display("[TB] ALU without operands");
    push_byte(8'hDD, 1'b0, 1'b0);
    push_byte(8'h07, 1'b0, 1'b0);
`ifdef HOST_CMD_GAP_EN
    apply_stimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 176);
`else
    apply_stimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 160);
`endif
    wait_done("alu_noop_done");

    repeat (20) @(negedge CLK);
    check_output("bytes_left", byte_q.size(), 0);
    check_output("dones_left", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
